// File: rtl/matrix_row_feeder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : matrix_row_feeder                                            |
// | Description : Fetches one batch of A row-chunks, vector-chunks and         |
// |               multiples counts from row RAM and presents them per lane.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module matrix_row_feeder #(
    parameter int ELEMENT_WIDTH                   = 32,
    parameter int NO_OF_ROW_BY_VECTOR_MODULES     = 4,
    parameter int NO_OF_ELEMENTS_IN_P_EMAP_OUTPUT = 8,
    parameter int MULTIPLES_MEMORY_VALUE_WIDTH    = 3,
    parameter int ADDR_WIDTH                      = 10
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        start,
    input  logic                                        memories_pre_preprocess,
    input  logic [NO_OF_ROW_BY_VECTOR_MODULES-1:0]      I_am_ready,
    input  logic [31:0]                                 total_with_additional_A,
    output logic                                        mem_rd_en,
    output logic [ADDR_WIDTH-1:0]                       mem_rd_addr,
    input  logic                                        mem_rd_valid,
    input  logic [2*NO_OF_ELEMENTS_IN_P_EMAP_OUTPUT*ELEMENT_WIDTH+MULTIPLES_MEMORY_VALUE_WIDTH-1:0] mem_rd_data,
    output logic [NO_OF_ROW_BY_VECTOR_MODULES*NO_OF_ELEMENTS_IN_P_EMAP_OUTPUT*ELEMENT_WIDTH-1:0]   A_rows,
    output logic [NO_OF_ROW_BY_VECTOR_MODULES*NO_OF_ELEMENTS_IN_P_EMAP_OUTPUT*ELEMENT_WIDTH-1:0]   vector_rows,
    output logic [NO_OF_ROW_BY_VECTOR_MODULES*MULTIPLES_MEMORY_VALUE_WIDTH-1:0]                     no_of_multiples,
    output logic [NO_OF_ROW_BY_VECTOR_MODULES-1:0]      you_can_read,
    output logic                                        busy,
    output logic                                        done
);

    localparam int c_n       = NO_OF_ROW_BY_VECTOR_MODULES;
    localparam int c_chunk_w = NO_OF_ELEMENTS_IN_P_EMAP_OUTPUT * ELEMENT_WIDTH;
    localparam int c_m       = MULTIPLES_MEMORY_VALUE_WIDTH;
    localparam int c_lane_w  = (c_n > 1) ? $clog2(c_n) : 1;
    localparam int c_ret_w   = $clog2(c_n + 1);
    localparam logic [31:0]         c_n32       = 32'(c_n);
    localparam logic [c_lane_w-1:0] c_last_lane = c_lane_w'(c_n - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_WAIT    = 3'd2,
        S_PRESENT = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [31:0]           r_batch;
    logic [c_lane_w-1:0]   r_issue;
    logic [c_ret_w-1:0]    r_ret;
    logic                  r_pending;
    logic [c_n-1:0]        r_ycr;
    logic [c_chunk_w-1:0]  r_a    [c_n];
    logic [c_chunk_w-1:0]  r_v    [c_n];
    logic [c_m-1:0]        r_mult [c_n];

    logic [31:0]           w_base;
    logic [31:0]           w_row;
    logic [31:0]           w_remain;
    logic                  w_row_valid;
    logic                  w_no_rows;
    logic                  w_last_batch;
    logic [c_ret_w-1:0]    w_lanes_used;
    logic                  w_busy_state;
    logic                  w_accept;
    logic                  w_load;
    logic [c_chunk_w-1:0]  w_rd_a;
    logic [c_chunk_w-1:0]  w_rd_v;
    logic [c_m-1:0]        w_rd_mult;

    assign w_base       = r_batch * c_n32;
    assign w_row        = w_base + 32'(r_issue);
    assign w_row_valid  = (w_row < total_with_additional_A);
    assign w_remain     = total_with_additional_A - w_base;
    assign w_no_rows    = (w_base >= total_with_additional_A);
    assign w_last_batch = (({1'b0, w_base} + {1'b0, c_n32}) >= {1'b0, total_with_additional_A});
    // Lanes past the end of the matrix never issue a read, so they are treated as already returned.
    assign w_lanes_used = (w_remain >= c_n32) ? c_ret_w'(c_n) : w_remain[c_ret_w-1:0];

    assign w_busy_state = (r_state == S_FETCH) || (r_state == S_WAIT) || (r_state == S_PRESENT);
    assign w_accept     = (r_state == S_IDLE) && start && (memories_pre_preprocess || r_pending);
    assign w_load       = ((r_state == S_FETCH) || (r_state == S_WAIT)) && mem_rd_valid
                          && (r_ret < w_lanes_used);

    assign w_rd_a    = mem_rd_data[2*c_chunk_w+c_m-1 -: c_chunk_w];
    assign w_rd_v    = mem_rd_data[c_chunk_w+c_m-1 -: c_chunk_w];
    assign w_rd_mult = mem_rd_data[c_m-1:0];

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:    if (w_accept) w_next_state = w_no_rows ? S_DONE : S_FETCH;
            S_FETCH:   if (r_issue == c_last_lane) w_next_state = S_WAIT;
            S_WAIT:    if (r_ret == w_lanes_used) w_next_state = S_PRESENT;
            S_PRESENT: if (r_ycr == '0) w_next_state = w_last_batch ? S_DONE : S_IDLE;
            S_DONE:    w_next_state = S_DONE;
            default:   w_next_state = S_IDLE;
        endcase
        if (!start) begin
            w_next_state = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_batch   <= '0;
            r_issue   <= '0;
            r_ret     <= '0;
            r_pending <= 1'b0;
            r_ycr     <= '0;
            for (int i = 0; i < c_n; i++) begin
                r_a[i]    <= '0;
                r_v[i]    <= '0;
                r_mult[i] <= '0;
            end
        end else if (!start) begin
            r_batch   <= '0;
            r_issue   <= '0;
            r_ret     <= '0;
            r_pending <= 1'b0;
            r_ycr     <= '0;
            for (int i = 0; i < c_n; i++) begin
                r_a[i]    <= '0;
                r_v[i]    <= '0;
                r_mult[i] <= '0;
            end
        end else begin
            if (w_accept) begin
                r_pending <= 1'b0;
            end else if (memories_pre_preprocess && w_busy_state) begin
                r_pending <= 1'b1;
            end

            if (w_accept) begin
                r_issue <= '0;
                r_ret   <= '0;
                for (int i = 0; i < c_n; i++) begin
                    r_a[i]    <= '0;
                    r_v[i]    <= '0;
                    r_mult[i] <= '0;
                end
            end

            if (r_state == S_FETCH) begin
                r_issue <= r_issue + c_lane_w'(1);
            end

            // RAM returns in order, so the return count names the lane to fill.
            if (w_load) begin
                r_a[r_ret[c_lane_w-1:0]]    <= w_rd_a;
                r_v[r_ret[c_lane_w-1:0]]    <= w_rd_v;
                r_mult[r_ret[c_lane_w-1:0]] <= w_rd_mult;
                r_ret                       <= r_ret + c_ret_w'(1);
            end

            if ((r_state == S_WAIT) && (r_ret == w_lanes_used)) begin
                r_ycr <= '1;
            end else if (r_state == S_PRESENT) begin
                r_ycr <= r_ycr & ~I_am_ready;
            end

            if ((r_state == S_PRESENT) && (r_ycr == '0)) begin
                r_batch <= r_batch + 32'd1;
            end
        end
    end

    assign mem_rd_en    = (r_state == S_FETCH) && w_row_valid;
    assign mem_rd_addr  = mem_rd_en ? w_row[ADDR_WIDTH-1:0] : '0;
    assign you_can_read = r_ycr;
    assign busy         = w_busy_state;
    assign done         = (r_state == S_DONE);

    generate
        for (genvar j = 0; j < c_n; j++) begin : g_lanes
            assign A_rows[(c_n-j)*c_chunk_w-1 -: c_chunk_w]  = r_a[j];
            assign vector_rows[(c_n-j)*c_chunk_w-1 -: c_chunk_w] = r_v[j];
            assign no_of_multiples[(c_n-j)*c_m-1 -: c_m]     = r_mult[j];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_matrix_row_feeder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_matrix_row_feeder                                         |
// | Description : Directed self-checking bench for matrix_row_feeder.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_matrix_row_feeder;

    localparam int N  = 4;
    localparam int E  = 8;
    localparam int W  = 32;
    localparam int M  = 3;
    localparam int AW = 10;
    localparam int CW = E * W;
    localparam int DW = 2 * CW + M;

    logic            clk   = 1'b0;
    logic            reset = 1'b0;
    logic            start = 1'b0;
    logic            req   = 1'b0;
    logic [N-1:0]    rdy   = '0;
    logic [31:0]     total = '0;
    logic            mem_rd_en;
    logic [AW-1:0]   mem_rd_addr;
    logic            mem_rd_valid = 1'b0;
    logic [DW-1:0]   mem_rd_data  = '0;
    logic [N*CW-1:0] A_rows;
    logic [N*CW-1:0] vector_rows;
    logic [N*M-1:0]  nmul;
    logic [N-1:0]    ycr;
    logic            busy;
    logic            done;

    int total_cnt = 0;
    int bad_cnt   = 0;
    int cyc       = 0;
    logic [AW-1:0] rd_addr_q [$];
    int            rd_cyc_q  [$];
    logic [N*CW-1:0] exp_a;

    matrix_row_feeder dut (
        .clk                     (clk),
        .reset                   (reset),
        .start                   (start),
        .memories_pre_preprocess (req),
        .I_am_ready              (rdy),
        .total_with_additional_A (total),
        .mem_rd_en               (mem_rd_en),
        .mem_rd_addr             (mem_rd_addr),
        .mem_rd_valid            (mem_rd_valid),
        .mem_rd_data             (mem_rd_data),
        .A_rows                  (A_rows),
        .vector_rows             (vector_rows),
        .no_of_multiples         (nmul),
        .you_can_read            (ycr),
        .busy                    (busy),
        .done                    (done)
    );

    always #5 clk = ~clk;

    function automatic logic [CW-1:0] fill(input int val);
        logic [31:0] x;
        x = 32'(val);
        return {E{x}};
    endfunction

    function automatic logic [DW-1:0] ram_row(input int r);
        logic [M-1:0] m;
        m = M'(r % 8);
        return {fill(r + 1), fill(2 * r), m};
    endfunction

    // Row RAM with one-cycle read latency; also logs every read address and cycle.
    always @(posedge clk) begin
        cyc          <= cyc + 1;
        mem_rd_valid <= mem_rd_en;
        mem_rd_data  <= ram_row(int'(mem_rd_addr));
        if (mem_rd_en === 1'b1) begin
            rd_addr_q.push_back(mem_rd_addr);
            rd_cyc_q.push_back(cyc);
        end
    end

    function automatic logic [CW-1:0] lane_a(input int j);
        return A_rows[(N-j)*CW-1 -: CW];
    endfunction

    function automatic logic [CW-1:0] lane_v(input int j);
        return vector_rows[(N-j)*CW-1 -: CW];
    endfunction

    function automatic logic [M-1:0] lane_m(input int j);
        return nmul[(N-j)*M-1 -: M];
    endfunction

    task automatic check(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
        total_cnt++;
        assert (obs === exp) else begin
            bad_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_req();
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
    endtask

    task automatic clear_log();
        rd_addr_q.delete();
        rd_cyc_q.delete();
    endtask

    task automatic flush(input logic [31:0] new_total);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        total = new_total;
    endtask

    task automatic wait_present(input string tag);
        int k;
        k = 0;
        while (ycr !== 4'hF && k < 40) begin
            @(negedge clk);
            k++;
        end
        check(tag, ycr, 4'hF);
    endtask

    task automatic wait_reads(input string tag, input int n);
        int k;
        k = 0;
        while (rd_addr_q.size() < n && k < 40) begin
            @(negedge clk);
            k++;
        end
        check(tag, rd_addr_q.size(), n);
    endtask

    task automatic release_all();
        rdy = 4'hF;
        @(negedge clk);
        rdy = 4'h0;
    endtask

    task automatic check_reads(input string tag, input int n, input int base);
        check({tag, "_count"}, rd_addr_q.size(), n);
        for (int i = 0; i < rd_addr_q.size() && i < n; i++) begin
            check({tag, "_addr"}, rd_addr_q[i], base + i);
            check({tag, "_cycle"}, rd_cyc_q[i] - rd_cyc_q[0], i);
        end
    endtask

    initial begin
        // Reset state
        tick(3);
        check("rst_ycr", ycr, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rd_en", mem_rd_en, 0);
        check("rst_a_rows", A_rows, 0);
        check("rst_mult", nmul, 0);
        reset = 1'b1;
        start = 1'b1;
        total = 32'd8;
        tick(2);

        // total=8, first batch
        clear_log();
        pulse_req();
        wait_present("b0_present");
        check_reads("b0_reads", 4, 0);
        check("b0_lane0_a", lane_a(0), fill(1));
        check("b0_lane2_v", lane_v(2), fill(4));
        check("b0_lane3_m", lane_m(3), 3);
        check("b0_busy", busy, 1);
        release_all();
        tick(1);
        check("b0_idle_busy", busy, 0);
        check("b0_idle_done", done, 0);

        // Second batch completes the matrix
        clear_log();
        pulse_req();
        wait_present("b1_present");
        check_reads("b1_reads", 4, 4);
        check("b1_lane0_a", lane_a(0), fill(5));
        check("b1_lane1_v", lane_v(1), fill(10));
        check("b1_lane3_m", lane_m(3), 7);
        release_all();
        tick(1);
        check("b1_done", done, 1);
        check("b1_busy", busy, 0);

        // A request while done is ignored
        clear_log();
        pulse_req();
        tick(4);
        check("done_req_reads", rd_addr_q.size(), 0);
        check("done_hold", done, 1);

        // total=6: partial final batch
        flush(32'd6);
        check("t6_flush_done", done, 0);
        clear_log();
        pulse_req();
        wait_present("t6_b0_present");
        check_reads("t6_b0_reads", 4, 0);
        release_all();
        tick(1);
        clear_log();
        pulse_req();
        wait_present("t6_b1_present");
        check_reads("t6_b1_reads", 2, 4);
        check("t6_lane1_a", lane_a(1), fill(6));
        check("t6_lane1_m", lane_m(1), 5);
        check("t6_lane2_a", lane_a(2), 0);
        check("t6_lane2_v", lane_v(2), 0);
        check("t6_lane2_m", lane_m(2), 0);
        check("t6_lane3_a", lane_a(3), 0);
        check("t6_lane3_m", lane_m(3), 0);
        release_all();
        tick(1);
        check("t6_done", done, 1);

        // Staggered release, lane 0 first
        flush(32'd8);
        pulse_req();
        wait_present("stag_present");
        exp_a = {fill(1), fill(2), fill(3), fill(4)};
        rdy = 4'b1000;
        @(negedge clk);
        check("stag_ycr_0111", ycr, 4'b0111);
        check("stag_a_hold1", A_rows, exp_a);
        rdy = 4'b0100;
        @(negedge clk);
        check("stag_ycr_0011", ycr, 4'b0011);
        check("stag_a_hold2", A_rows, exp_a);
        rdy = 4'b0010;
        @(negedge clk);
        check("stag_ycr_0001", ycr, 4'b0001);
        check("stag_a_hold3", A_rows, exp_a);
        rdy = 4'b0001;
        @(negedge clk);
        rdy = 4'b0000;
        check("stag_ycr_0000", ycr, 4'b0000);
        check("stag_busy_still", busy, 1);
        tick(1);
        check("stag_busy_drop", busy, 0);

        // Pending request: one queued batch, further pulses dropped
        flush(32'd12);
        clear_log();
        pulse_req();
        wait_reads("pend_fetch_reads", 4);
        pulse_req();
        wait_present("pend_b0_present");
        pulse_req();
        check_reads("pend_b0_reads", 4, 0);
        clear_log();
        release_all();
        wait_present("pend_b1_present");
        check_reads("pend_b1_reads", 4, 4);
        check("pend_b1_lane0_a", lane_a(0), fill(5));
        release_all();
        tick(1);
        check("pend_b1_busy", busy, 0);
        clear_log();
        tick(6);
        check("pend_dropped_reads", rd_addr_q.size(), 0);
        check("pend_dropped_busy", busy, 0);
        check("pend_dropped_done", done, 0);

        // Asynchronous reset in the middle of a fetch
        flush(32'd8);
        clear_log();
        pulse_req();
        check("arst_fetch_rd_en", mem_rd_en, 1);
        #2;
        reset = 1'b0;
        #1;
        check("arst_rd_en", mem_rd_en, 0);
        check("arst_addr", mem_rd_addr, 0);
        check("arst_busy", busy, 0);
        check("arst_ycr", ycr, 0);
        @(negedge clk);
        reset = 1'b1;
        clear_log();
        tick(5);
        check("arst_idle_reads", rd_addr_q.size(), 0);
        check("arst_idle_busy", busy, 0);
        pulse_req();
        wait_present("arst_b0_present");
        check_reads("arst_b0_reads", 4, 0);
        release_all();
        tick(1);

        // start dropped while presenting the second batch
        clear_log();
        pulse_req();
        wait_present("sd_b1_present");
        check_reads("sd_b1_reads", 4, 4);
        start = 1'b0;
        @(negedge clk);
        check("sd_ycr", ycr, 0);
        check("sd_busy", busy, 0);
        start = 1'b1;
        clear_log();
        pulse_req();
        wait_present("sd_restart_present");
        check_reads("sd_restart_reads", 4, 0);
        check("sd_restart_lane0_a", lane_a(0), fill(1));
        release_all();
        tick(1);

        // Empty matrix goes straight to done
        flush(32'd0);
        clear_log();
        pulse_req();
        tick(2);
        check("t0_done", done, 1);
        check("t0_reads", rd_addr_q.size(), 0);
        check("t0_ycr", ycr, 0);
        check("t0_busy", busy, 0);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
`default_nettype wire
